// File: rtl/default_reset_seq_gen_pkg.sv
// Shared types for the reset sequencer: FSM states and a set-bit search helper.
package default_reset_seq_pkg;

    localparam int IDX_W    = 5;
    localparam int MAX_CHAN = 32;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STAGGER,
        ST_IDLE
    } seq_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } set_bit_t;

    // Lowest set bit of mask strictly above after_idx; after_idx = -1 searches from bit 0.
    function automatic set_bit_t next_set_bit(input logic [MAX_CHAN-1:0] mask, input int after_idx);
        set_bit_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAX_CHAN - 1; i >= 0; i--) begin
            if (mask[i] && (i > after_idx)) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/default_reset_seq_gen_if.sv
// Software request in, per-channel reset levels and sequence status out.
interface default_reset_seq_gen_if #(
    parameter int N_CHAN = 4
);
    logic              SW_REQ;
    logic [N_CHAN-1:0] CHAN_MASK;
    logic [N_CHAN-1:0] RST_OUT;
    logic              BUSY;
    logic              DONE;

    modport master (output SW_REQ, CHAN_MASK, input RST_OUT, BUSY, DONE);
    modport slave  (input SW_REQ, CHAN_MASK, output RST_OUT, BUSY, DONE);
endinterface

// File: rtl/default_reset_seq_gen_next_chan.sv
// Combinational priority encoder: next masked channel above the last released one,
// plus a flag telling whether it is the final masked channel.
module default_reset_seq_next_chan
    import default_reset_seq_pkg::*;
#(
    parameter int N_CHAN = 4
) (
    input  logic [N_CHAN-1:0] mask_i,
    input  logic              first_i,
    input  logic [IDX_W-1:0]  last_idx_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              last_o
);
    logic [MAX_CHAN-1:0] mask_ext;
    logic [MAX_CHAN-1:0] above;
    set_bit_t            cur;

    always_comb begin
        mask_ext                = '0;
        mask_ext[N_CHAN-1:0]    = mask_i;
        cur   = next_set_bit(mask_ext, first_i ? -1 : int'(last_idx_i));
        // Bits strictly above cur.idx; shift by 32 yields zero so idx 31 leaves nothing above.
        above = ~((32'd2 << cur.idx) - 32'd1);
    end

    assign idx_o  = cur.found ? cur.idx : '0;
    assign last_o = ~|(mask_ext & above);

endmodule

// File: rtl/default_reset_seq_gen.sv
// Multi-channel reset sequencer: hold all selected resets, then release them in
// ascending order with a fixed stagger. Outputs are registered.
module default_reset_seq_gen
    import default_reset_seq_pkg::*;
#(
    parameter int                N_CHAN          = 4,
    parameter int                HOLD_CYCLES     = 5,
    parameter int                STAGGER_CYCLES  = 2,
    parameter logic [N_CHAN-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic                    CLK_IN,
    input  logic                    RESET,
    default_reset_seq_gen_if.slave  bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger
        $error("STAGGER_CYCLES must be >= 1");
    end
    if (N_CHAN < 1 || N_CHAN > MAX_CHAN) begin : g_bad_nchan
        $error("N_CHAN must be within 1..32");
    end

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CHAN-1:0] mask_q, mask_d;
    logic [N_CHAN-1:0] asrt_q, asrt_d;
    logic [IDX_W-1:0]  last_idx_q, last_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  rel_idx;
    logic              rel_last;
    logic              release_now;
    logic              accept;

    default_reset_seq_next_chan #(.N_CHAN(N_CHAN)) u_next_chan (
        .mask_i     (mask_q),
        .first_i    (state_q == ST_HOLD),
        .last_idx_i (last_idx_q),
        .idx_o      (rel_idx),
        .last_o     (rel_last)
    );

    assign release_now = ((state_q == ST_HOLD)    && (cnt_q == CNT_W'(HOLD_CYCLES - 1))) ||
                         ((state_q == ST_STAGGER) && (cnt_q == CNT_W'(STAGGER_CYCLES - 1)));
    assign accept      = (state_q == ST_IDLE) && bus.SW_REQ && (|bus.CHAN_MASK);

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            mask_q     <= '1;
            asrt_q     <= '1;
            last_idx_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            asrt_q     <= asrt_d;
            last_idx_q <= last_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD, ST_STAGGER: if (release_now) state_d = rel_last ? ST_IDLE : ST_STAGGER;
            ST_IDLE:             if (accept)      state_d = ST_HOLD;
            default:             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        asrt_d     = asrt_q;
        last_idx_d = last_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if (state_q != ST_IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (release_now) begin
                for (int i = 0; i < N_CHAN; i++) begin
                    if (rel_idx == IDX_W'(i)) asrt_d[i] = 1'b0;
                end
                last_idx_d = rel_idx;
                cnt_d      = '0;
                if (rel_last) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end else if (accept) begin
            // Channels outside the request mask are already deasserted in idle and stay so.
            mask_d = bus.CHAN_MASK;
            asrt_d = asrt_q | bus.CHAN_MASK;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    assign bus.RST_OUT = asrt_q ^ ACTIVE_LOW_MASK;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;

endmodule

// File: doc/default_reset_seq_gen.md
# default_reset_seq_gen

Parametrised multi-channel reset sequencer for QVIP testbenches. It replaces single-output fixed-length reset generation with N independently polarised reset outputs. Outputs are held for a programmable number of cycles after power-on or a software request, then released one at a time in ascending channel order with a fixed stagger. It sits in the uvm_tb top beside the clock generator and drives the reset pins of each VIP/DUT interface.

## Interface
- `N_CHAN`, 4: number of reset outputs (1..32)
- `HOLD_CYCLES`, 5: cycles all selected channels stay asserted before the first release (>=1)
- `STAGGER_CYCLES`, 2: cycles between successive channel releases (>=1)
- `ACTIVE_LOW_MASK`, '0: bit i=1 makes `RST_OUT[i]` active-low
- `CLK_IN`  input  1  sole clock; all logic on posedge
- `RESET`  input  1  synchronous, active-high; one clock, synchronous active-high reset
- `SW_REQ`  input  1  software reset request, sampled each edge
- `CHAN_MASK`  input  N_CHAN  channels affected by `SW_REQ`, captured on accept
- `RST_OUT`  output  N_CHAN  per-channel reset, registered, polarity per `ACTIVE_LOW_MASK`
- `BUSY`  output  1  sequence in progress
- `DONE`  output  1  one-cycle pulse when a sequence completes

## Operation
- Internal asserted vector `asrt[N_CHAN]`; `RST_OUT[i] = asrt[i] ^ ACTIVE_LOW_MASK[i]`, registered. No combinational path from inputs to outputs.
- States: `ST_HOLD`, `ST_STAGGER`, `ST_IDLE`.
- While `RESET`=1:
  - `asrt`=all ones, mask_q=all ones, state=`ST_HOLD`, cnt=0.
  - `BUSY`=1, `DONE`=0.
  - Each output reads its asserted level: 1 for active-high, 0 for active-low.
- `ST_HOLD`: cnt increments each edge. On the edge where cnt==HOLD_CYCLES-1, the lowest set bit of mask_q is cleared in `asrt`, cnt=0, and the state goes to `ST_STAGGER`. If that channel is the only masked one, go straight to `ST_IDLE`.
- `ST_STAGGER`:
  - cnt increments each edge.
  - On the edge where cnt==STAGGER_CYCLES-1, clear the next set bit of mask_q above the last released index. Unmasked indices are skipped with no delay.
  - cnt resets to 0.
- Last release edge: state=`ST_IDLE`, `BUSY`<=0, `DONE`<=1 for exactly one cycle.
- `ST_IDLE`: with `SW_REQ`=1 and `CHAN_MASK`!=0, the next edge:
  - captures mask_q=`CHAN_MASK`, sets `asrt`|=`CHAN_MASK`, cnt=0;
  - sets `BUSY`=1 and enters `ST_HOLD`.
  
  Channels outside the mask stay deasserted for the whole sequence.
- `SW_REQ` with `CHAN_MASK`==0 is ignored: no `BUSY`, no `DONE`.
- `SW_REQ` while `BUSY`=1 is ignored and not queued.
- `RESET` asserted mid-sequence overrides everything. All channels reassert on the next edge, `DONE` clears, and the sequence restarts with the full mask.
- `RESET` has priority over `SW_REQ` on the same edge.

## Timing
- Edge 0 is the last edge sampling `RESET`=1. Under the full mask, channel k deasserts at edge HOLD_CYCLES + k·STAGGER_CYCLES.
- Defaults: ch0@5, ch1@7, ch2@9, ch3@11. `BUSY` falls and `DONE` rises at edge 11; `DONE` falls at edge 12.
- SW sequence: with accept at edge a, the first masked channel releases at a+HOLD_CYCLES and each following masked channel STAGGER_CYCLES later.
- `SW_REQ` is accepted at the earliest on the edge after `DONE` rises, when the state is `ST_IDLE`.
- cnt width is $clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1). Counter never wraps because it is cleared on every transition.
- Elaboration error if HOLD_CYCLES<1, STAGGER_CYCLES<1, or N_CHAN outside 1..32.

## Structure
- Package `default_reset_seq_pkg`: state enum `seq_state_t` and function `next_set_bit(mask, after_idx)` returning the index plus a found flag.
- One natural sub-module: `default_reset_seq_next_chan`, a combinational priority encoder yielding the next masked index above the current one and a last-channel flag. The FSM and counter stay in the top.

## Test plan
- Power-on, defaults: `RESET` high 3 cycles then low.
  - `RST_OUT`=4'b1111 → 4'b1110@5, 4'b1100@7, 4'b1000@9, 4'b0000@11.
  - `DONE` high only in cycle 11–12.
- `ACTIVE_LOW_MASK`=4'b0101: during reset `RST_OUT`=4'b1010; after completion 4'b0101.
- SW partial: in idle, `SW_REQ` with `CHAN_MASK`=4'b1010 at edge a.
  - `RST_OUT`=4'b1010 at a+1; ch1 releases at a+5, ch3 at a+7.
  - ch0 and ch2 never assert; `DONE` at a+7.
- SW_REQ during BUSY, and SW_REQ with mask 0 in idle: no state change, no `DONE`, `RST_OUT` timing identical to the undisturbed run.
- `RESET` reasserted at edge 8 (after ch1 released): `RST_OUT`=4'b1111 next edge. The full default sequence restarts from the new `RESET` fall.
- Corner parameters HOLD_CYCLES=1, STAGGER_CYCLES=1, N_CHAN=1: output deasserts 1 edge after `RESET` falls, with `DONE` on the same edge.
